// File: rtl/wave_sequencer_pkg.sv
// Shared types and default widths for the waveform sequencer.
package wave_sequencer_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_PHASE_W = 24;
    localparam int CYCLES_W    = 8;
    localparam int ROM_DATA_W  = 16;

    typedef enum logic [1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_SAW      = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/wave_sequencer_if.sv
// Config handshake and waveform ROM bus; master is the sequencer side.
interface wave_sequencer_if #(
    parameter int ADDR_W  = wave_sequencer_pkg::DEF_ADDR_W,
    parameter int PHASE_W = wave_sequencer_pkg::DEF_PHASE_W
) ();
    logic                                      cfg_valid;
    logic                                      cfg_ready;
    logic [1:0]                                cfg_wave;
    logic [PHASE_W-1:0]                        cfg_ftw;
    logic [wave_sequencer_pkg::CYCLES_W-1:0]   cfg_cycles;
    logic                                      rom_en;
    logic [1:0]                                rom_sel;
    logic [ADDR_W-1:0]                         rom_addr;
    logic [wave_sequencer_pkg::ROM_DATA_W-1:0] rom_data;

    modport master (
        input  cfg_valid, cfg_wave, cfg_ftw, cfg_cycles, rom_data,
        output cfg_ready, rom_en, rom_sel, rom_addr
    );

    modport slave (
        output cfg_valid, cfg_wave, cfg_ftw, cfg_cycles, rom_data,
        input  cfg_ready, rom_en, rom_sel, rom_addr
    );
endinterface

// File: rtl/wave_phase_acc.sv
// Phase accumulator; wrap is the carry-out of the current increment.
module wave_phase_acc
    import wave_sequencer_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap
);

    logic [PHASE_W:0] sum;

    assign sum  = {1'b0, phase} + {1'b0, ftw};
    assign wrap = en & sum[PHASE_W];

    // clear wins over advance so a config swap restarts the period at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= sum[PHASE_W-1:0];
        end
    end

endmodule

// File: rtl/wave_sequencer.sv
// Waveform playback controller: phase-driven ROM reads with a shadowed config.
// state | meaning
// IDLE  | waiting for start; accepted config loads the active registers
// RUN   | phase advancing, one ROM read per clock
// FLUSH | reads stopped, last outstanding sample returns
module wave_sequencer
    import wave_sequencer_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    wave_sequencer_if.master  bus,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              period_done
);

    state_t                state, state_nxt;
    wave_t                 act_wave, shd_wave;
    logic [PHASE_W-1:0]    act_ftw, shd_ftw;
    logic [CYCLES_W-1:0]   act_cycles, shd_cycles, cnt;
    logic                  shd_full, stop_q;
    logic [PHASE_W-1:0]    phase;
    logic                  wrap, terminal, cfg_acc, launch, promote, acc_clr;
    logic                  bits_unused;

    assign cfg_acc  = bus.cfg_valid & bus.cfg_ready;
    assign terminal = wrap & (stop_q | ((act_cycles != '0) && (cnt == CYCLES_W'(1))));
    assign launch   = (state == ST_IDLE) && (state_nxt == ST_RUN);
    // a pending shadow is promoted at a wrap, or at FLUSH if the run ended without one
    assign promote  = shd_full & (wrap | (state == ST_FLUSH));
    assign acc_clr  = (state == ST_IDLE) | (wrap & shd_full);

    assign bus.rom_addr = phase[PHASE_W-1 -: ADDR_W];
    assign bus.rom_sel  = act_wave;
    assign bits_unused  = ^{bus.rom_data, phase};

    wave_phase_acc #(.PHASE_W(PHASE_W)) u_phase_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (state == ST_RUN),
        .ftw   (act_ftw),
        .phase (phase),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cfg_ready = 1'b0;
        bus.rom_en    = 1'b0;
        busy          = 1'b1;
        case (state)
            ST_IDLE: begin
                bus.cfg_ready = 1'b1;
                busy          = 1'b0;
                if (start && (act_ftw != '0)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.rom_en    = 1'b1;
                bus.cfg_ready = ~shd_full;
                // a zero increment never wraps, so a latched stop ends the run directly
                if (terminal || (stop_q && (act_ftw == '0))) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_wave   <= WAVE_SINE;
            act_ftw    <= '0;
            act_cycles <= '0;
            shd_wave   <= WAVE_SINE;
            shd_ftw    <= '0;
            shd_cycles <= '0;
            shd_full   <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && cfg_acc) begin
                act_wave   <= wave_t'(bus.cfg_wave);
                act_ftw    <= bus.cfg_ftw;
                act_cycles <= bus.cfg_cycles;
            end else if (promote) begin
                act_wave   <= shd_wave;
                act_ftw    <= shd_ftw;
                act_cycles <= shd_cycles;
            end
            if ((state == ST_RUN) && cfg_acc) begin
                shd_wave   <= wave_t'(bus.cfg_wave);
                shd_ftw    <= bus.cfg_ftw;
                shd_cycles <= bus.cfg_cycles;
                shd_full   <= 1'b1;
            end else if (promote) begin
                shd_full   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stop_q <= 1'b0;
        end else begin
            stop_q <= (state == ST_RUN) & (stop_q | stop);
            if (launch) begin
                cnt <= act_cycles;
            end else if (wrap) begin
                if (shd_full) begin
                    cnt <= shd_cycles;
                end else if (act_cycles != '0) begin
                    cnt <= cnt - CYCLES_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            period_done  <= 1'b0;
        end else begin
            sample_valid <= bus.rom_en;
            period_done  <= wrap;
            if (bus.rom_en) begin
                sample <= bus.rom_data[ROM_DATA_W-1 -: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer; the ROM model returns the low address byte in the top byte.
module tb_wave_sequencer;
    import wave_sequencer_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int PHASE_W = 24;
    localparam int DATA_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [DATA_W-1:0] sample;
    logic              sample_valid, busy, period_done;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int pd_cnt = 0;
    int sv_cnt = 0;

    wave_sequencer_if #(.ADDR_W(ADDR_W), .PHASE_W(PHASE_W)) bus ();

    wave_sequencer #(.ADDR_W(ADDR_W), .PHASE_W(PHASE_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .bus          (bus),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .period_done  (period_done)
    );

    always #5 clk = ~clk;

    always_comb bus.rom_data = {bus.rom_addr[7:0], 6'h00, bus.rom_sel};

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        t++;
        pd_cnt += int'(period_done);
        sv_cnt += int'(sample_valid);
    endtask

    task automatic go_to(input int n);
        while (t < n) cyc();
    endtask

    task automatic offer(input logic [1:0] wave, input logic [23:0] ftw, input logic [7:0] cycles);
        bus.cfg_valid  = 1'b1;
        bus.cfg_wave   = wave;
        bus.cfg_ftw    = ftw;
        bus.cfg_cycles = cycles;
        cyc();
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        t      = 0;
        pd_cnt = 0;
        sv_cnt = 0;
    endtask

    task automatic finish_run(input string tag, input int exp_t, input int exp_pd);
        while (busy === 1'b1 && t < exp_t + 20) cyc();
        chk({tag, "_end_cycle"}, t, exp_t);
        chk({tag, "_periods"}, pd_cnt, exp_pd);
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_wave   = 2'd0;
        bus.cfg_ftw    = '0;
        bus.cfg_cycles = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rom_en", bus.rom_en, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_rom_sel", bus.rom_sel, 0);
        chk("rst_sample", sample, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_period_done", period_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cfg_ready", bus.cfg_ready, 1);

        // start with zero tuning word is ignored
        offer(2'd1, 24'h000000, 8'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ftw0_busy", busy, 0);
        chk("ftw0_rom_en", bus.rom_en, 0);

        // one period of triangle, step 1
        offer(2'd2, 24'h004000, 8'd1);
        start_run();
        chk("p38_rom_sel", bus.rom_sel, 2);
        chk("p38_sv_first", sample_valid, 0);
        for (int k = 0; k < 1024; k++) begin
            go_to(k);
            chk("p38_addr", bus.rom_addr, k);
            chk("p38_rom_en", bus.rom_en, 1);
            if (k > 0) chk("p38_sample", sample, (k - 1) & 255);
        end
        go_to(1024);
        chk("p38_flush_rom_en", bus.rom_en, 0);
        chk("p38_flush_busy", busy, 1);
        chk("p38_flush_sv", sample_valid, 1);
        chk("p38_flush_sample", sample, 8'hFF);
        chk("p38_flush_pd", period_done, 1);
        go_to(1025);
        chk("p38_idle_busy", busy, 0);
        chk("p38_idle_sv", sample_valid, 0);
        chk("p38_hold_sample", sample, 8'hFF);
        chk("p38_idle_cfg_ready", bus.cfg_ready, 1);
        chk("p38_periods", pd_cnt, 1);
        chk("p38_samples", sv_cnt, 1024);

        // continuous step 4; stop in IDLE ignored, stop mid second period
        offer(2'd0, 24'h010000, 8'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        start_run();
        go_to(1);
        chk("p39_addr1", bus.rom_addr, 4);
        go_to(100);
        chk("p39_addr100", bus.rom_addr, 400);
        go_to(255);
        chk("p39_addr255", bus.rom_addr, 1020);
        go_to(256);
        chk("p39_wrap_addr", bus.rom_addr, 0);
        chk("p39_wrap_pd", period_done, 1);
        go_to(356);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        finish_run("p39", 513, 2);

        // shadow config swaps in at the next wrap
        offer(2'd0, 24'h010000, 8'd0);
        start_run();
        go_to(100);
        chk("p40_ready_before", bus.cfg_ready, 1);
        offer(2'd3, 24'h008000, 8'd0);
        chk("p40_ready_full", bus.cfg_ready, 0);
        chk("p40_sel_old", bus.rom_sel, 0);
        go_to(255);
        chk("p40_sel_pre_wrap", bus.rom_sel, 0);
        chk("p40_addr_pre_wrap", bus.rom_addr, 1020);
        go_to(256);
        chk("p40_sel_wrap", bus.rom_sel, 3);
        chk("p40_addr_wrap", bus.rom_addr, 0);
        chk("p40_ready_after", bus.cfg_ready, 1);
        go_to(257);
        chk("p40_step2_a", bus.rom_addr, 2);
        go_to(258);
        chk("p40_step2_b", bus.rom_addr, 4);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        finish_run("p40", 769, 2);

        // config accepted in the wrap clock waits a full period; finite count reload
        offer(2'd1, 24'h010000, 8'd3);
        start_run();
        go_to(255);
        chk("p41_ready_wrapclk", bus.cfg_ready, 1);
        offer(2'd2, 24'h020000, 8'd1);
        chk("p41_sel_wrap1", bus.rom_sel, 1);
        chk("p41_addr_wrap1", bus.rom_addr, 0);
        chk("p41_pd_wrap1", period_done, 1);
        chk("p41_ready_full", bus.cfg_ready, 0);
        go_to(257);
        chk("p41_old_step", bus.rom_addr, 4);
        go_to(511);
        chk("p41_sel_pre", bus.rom_sel, 1);
        go_to(512);
        chk("p41_sel_wrap2", bus.rom_sel, 2);
        chk("p41_addr_wrap2", bus.rom_addr, 0);
        go_to(513);
        chk("p41_new_step", bus.rom_addr, 8);
        finish_run("p41", 641, 3);

        // zero increment promoted mid-run, then stop ends the run without a wrap
        offer(2'd0, 24'h010000, 8'd0);
        start_run();
        go_to(10);
        offer(2'd1, 24'h000000, 8'd0);
        go_to(256);
        chk("p29_sel", bus.rom_sel, 1);
        chk("p29_rom_en", bus.rom_en, 1);
        go_to(260);
        chk("p29_frozen_addr", bus.rom_addr, 0);
        chk("p29_busy", busy, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("p29_latched_run", bus.rom_en, 1);
        cyc();
        chk("p29_flush_rom_en", bus.rom_en, 0);
        chk("p29_flush_busy", busy, 1);
        finish_run("p29", 263, 1);

        // reset during RUN aborts at once
        offer(2'd3, 24'h004000, 8'd0);
        start_run();
        go_to(341);
        chk("p42_addr", bus.rom_addr, 10'h155);
        #2 rst_n = 1'b0;
        #1;
        chk("p42_rom_en", bus.rom_en, 0);
        chk("p42_busy", busy, 0);
        chk("p42_rom_addr", bus.rom_addr, 0);
        chk("p42_rom_sel", bus.rom_sel, 0);
        chk("p42_sample", sample, 0);
        chk("p42_sv", sample_valid, 0);
        chk("p42_pd", period_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("p42_cfg_ready", bus.cfg_ready, 1);
        repeat (2) @(negedge clk);
        chk("p42_post_rom_en", bus.rom_en, 0);
        chk("p42_post_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, waveform ROM address width (1024 samples per period).
REQ-002 SHALL have parameter PHASE_W, default 24, phase accumulator width.
REQ-003 SHALL have parameter DATA_W, default 8, output sample width.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request to begin playback; sampled in IDLE only.
REQ-007 stop  in  1  request graceful stop at next period boundary.
REQ-008 cfg_valid  in  1  new configuration offered.
REQ-009 cfg_ready  out  1  configuration can be accepted this cycle.
REQ-010 cfg_wave  in  2  waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-011 cfg_ftw  in  PHASE_W  frequency tuning word (phase increment per clock).
REQ-012 cfg_cycles  in  8  number of periods to play; 0 means continuous.
REQ-013 rom_en  out  1  ROM read strobe.
REQ-014 rom_sel  out  2  ROM bank select (active waveform).
REQ-015 rom_addr  out  ADDR_W  ROM read address.
REQ-016 rom_data  in  16  ROM read data, valid one clock after rom_en.
REQ-017 sample  out  DATA_W  output sample, equal to rom_data[15:16-DATA_W].
REQ-018 sample_valid  out  1  sample is new this cycle.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 period_done  out  1  one-clock pulse at each phase wrap.

Function
REQ-021 FSM SHALL have states IDLE, RUN, FLUSH; IDLE->RUN on start with active ftw != 0; RUN->FLUSH on terminal wrap; FLUSH->IDLE after exactly one clock.
REQ-022 In RUN, phase SHALL advance by active ftw every clock, modulo 2^PHASE_W; rom_addr SHALL equal phase[PHASE_W-1 -: ADDR_W] registered; rom_en SHALL be 1.
REQ-023 A wrap SHALL be the carry-out of the phase addition; period_done SHALL pulse in the same clock that rom_addr shows the post-wrap address.
REQ-024 In IDLE, cfg_ready SHALL be 1 and an accepted config (cfg_valid & cfg_ready) SHALL load the active registers directly.
REQ-025 In RUN, an accepted config SHALL load a single-entry shadow register; cfg_ready SHALL be 0 while the shadow is full; shadow SHALL move to active at the next wrap, which also reloads the period counter and resets phase to 0.
REQ-026 Config accepted in the same clock as a wrap SHALL apply at the following wrap, not the current one.
REQ-027 Finite mode: period counter SHALL decrement at each wrap; the wrap bringing it to 0 is terminal.
REQ-028 stop SHALL latch; the next wrap is terminal regardless of the counter; stop in IDLE SHALL be ignored.
REQ-029 If stop is latched with active ftw == 0 in RUN, FSM SHALL go to FLUSH next clock.
REQ-030 start with active ftw == 0 SHALL be ignored.
REQ-031 In FLUSH, rom_en SHALL be 0; sample_valid SHALL be 1 for the last outstanding read.
REQ-032 sample and sample_valid SHALL be registered, one clock after the corresponding rom_en; sample SHALL hold its value when sample_valid is 0.
REQ-033 start asserted while busy SHALL be ignored.

Reset
REQ-034 On rst_n low, state SHALL be IDLE; phase, active/shadow config, counters, rom_addr, rom_sel, sample = 0; rom_en, sample_valid, period_done, busy, stop latch = 0; cfg_ready = 1 after release.
REQ-035 Reset asserted mid-RUN SHALL abort immediately with no further ROM reads.

Structure
REQ-036 A shared package SHALL hold the wave-select enumeration, the FSM state type and default ADDR_W/PHASE_W.
REQ-037 The phase accumulator with wrap detect SHALL be the sub-module wave_phase_acc; FSM and config handling stay in wave_sequencer.

Verification (PHASE_W=24, ADDR_W=10)
REQ-038 cfg ftw=0x004000, wave=2, cycles=1, start -> rom_addr 0..1023 in consecutive clocks, one period_done, 1024 sample_valid, busy falls after FLUSH.
REQ-039 ftw=0x010000, cycles=0, stop mid-period -> addresses step 4, playback ends at next wrap, period_done count = periods completed.
REQ-040 RUN with wave=0, offer wave=3 ftw=0x008000 mid-period -> cfg_ready drops, rom_sel changes to 3 exactly at next wrap, step becomes 2.
REQ-041 cfg_valid in the wrap clock -> new config applies only at the following wrap.
REQ-042 rst_n low during RUN at address 0x155 -> all outputs 0 same cycle, IDLE, cfg_ready 1 after release.
REQ-043 start with ftw=0 -> busy stays 0, rom_en stays 0.
